// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and shared state type for the MIPS datapath.
// Used by the ALU decode and the iterative multiply/divide unit.
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_AND   = 5'b00000;
    localparam logic [4:0] ALU_OR    = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_XOR   = 5'b00011;
    localparam logic [4:0] ALU_DIV   = 5'b00100;
    localparam logic [4:0] ALU_NOR   = 5'b00101;
    localparam logic [4:0] ALU_SUB   = 5'b00110;
    localparam logic [4:0] ALU_SLT   = 5'b00111;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_MULT  = 5'b01001;
    localparam logic [4:0] ALU_MULTU = 5'b01010;
    localparam logic [4:0] ALU_DIVU  = 5'b01011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: add-shift right. Divide: restoring trial-subtract, shift left.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + (acc_i[0] ? {1'b0, opd_i} : {(WIDTH+1){1'b0}});
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opd_i};
        if (div_i) begin
            // trial[WIDTH] set means the partial remainder was below the divisor
            if (!trial[WIDTH])
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            else
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Signed ops run on magnitudes; signs are applied in the FIX state.
module muldiv_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    md_state_e state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod_fix;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic               is_div_q, is_div_d, dz_q, dz_d;
    logic               qsign_q, qsign_d, rsign_q, rsign_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               op_mul, op_div, op_sgn, accept, b_zero, iter;

    assign op_mul = (op == ALU_MULT) || (op == ALU_MULTU);
    assign op_div = (op == ALU_DIV) || (op == ALU_DIVU);
    assign op_sgn = (op == ALU_MULT) || (op == ALU_DIV);
    assign b_zero = (b == '0);
    assign accept = (state_q == S_IDLE) && start && (op_mul || op_div);
    assign a_mag  = (op_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (op_sgn && b[WIDTH-1]) ? -b : b;

    assign iter = ((state_q == S_MUL) || (state_q == S_DIV))
                && (cnt_q != CNT_LAST) && !dz_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .opd_i (opd_q),
        .div_i (is_div_q),
        .acc_o (acc_step)
    );

    assign prod_fix = qsign_q ? -acc_q : acc_q;
    assign quo_fix  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = op_mul ? S_MUL : S_DIV;
            end
            S_MUL: begin
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                // a zero divisor skips the iterations and the HI/LO write
                if (dz_q)                   state_d = S_DONE;
                else if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        dbz_d  = (state_q == S_DIV) && dz_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
            opd_d    = op_mul ? a_mag : b_mag;
            is_div_d = op_div;
            dz_d     = op_div && b_zero;
            qsign_d  = op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_d  = op_sgn && a[WIDTH-1];
        end else if (state_q == S_IDLE) begin
            if (wr_hi) hi_d = a;
            if (wr_lo) lo_d = a;
        end
        if (iter) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == S_FIX) begin
            if (is_div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
            else          {hi_d, lo_d} = prod_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
